// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
//   Shared encodings for the EX pipeline stage: the ALUOp codes the control
//   unit emits, the bundle of control bits carried into MEM, and the default
//   datapath width.
// -----------------------------------------------------------------------------
package execute_stage_pkg;

  localparam int DATA_W_DEF = 64;

  // ALU operation select as produced by the control unit / ALU control.
  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0110,
    ALU_PASS_B = 4'b0111
  } alu_op_e;

  // Control bits that travel with the instruction from EX into MEM. These are
  // the bits a flush must squash; the data fields travel separately.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem2reg;
    logic pc_src;
  } mem_ctrl_t;

  localparam mem_ctrl_t MEM_CTRL_NOP = '0;

endpackage

// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : the surrounding pipeline (drives *_EX, observes *_MEM)
//   slave  : execute_stage (consumes *_EX, drives *_MEM)
// -----------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int DATA_W = 64
);

  // ID/EX side
  logic              RegWrite_EX;
  logic              ALUSrc_EX;
  logic              Branch_EX;
  logic              Uncondbranch_EX;
  logic              MemRead_EX;
  logic              MemWrite_EX;
  logic              Mem2Reg_EX;
  logic [3:0]        ALUOp_EX;
  logic [4:0]        RD_EX;
  logic [DATA_W-1:0] RegOutA_EX;
  logic [DATA_W-1:0] RegOutB_EX;
  logic [DATA_W-1:0] SignExtImm64_EX;
  logic [DATA_W-1:0] pc_EX;

  // EX/MEM side
  logic              RegWrite_MEM;
  logic              MemRead_MEM;
  logic              MemWrite_MEM;
  logic              Mem2Reg_MEM;
  logic              PCSrc_MEM;
  logic [4:0]        RD_MEM;
  logic [DATA_W-1:0] ALUResult_MEM;
  logic [DATA_W-1:0] WriteData_MEM;
  logic [DATA_W-1:0] BranchTarget_MEM;
  logic              Zero_MEM;

  modport master (
    output RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX, MemRead_EX,
           MemWrite_EX, Mem2Reg_EX, ALUOp_EX, RD_EX, RegOutA_EX, RegOutB_EX,
           SignExtImm64_EX, pc_EX,
    input  RegWrite_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, PCSrc_MEM,
           RD_MEM, ALUResult_MEM, WriteData_MEM, BranchTarget_MEM, Zero_MEM
  );

  modport slave (
    input  RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX, MemRead_EX,
           MemWrite_EX, Mem2Reg_EX, ALUOp_EX, RD_EX, RegOutA_EX, RegOutB_EX,
           SignExtImm64_EX, pc_EX,
    output RegWrite_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, PCSrc_MEM,
           RD_MEM, ALUResult_MEM, WriteData_MEM, BranchTarget_MEM, Zero_MEM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
//   Purely combinational ALU for the execute stage.
//   A, B    : operands
//   ALUOp   : operation select (alu_op_e codes; anything else gives 0)
//   result  : operation result, modulo 2^DATA_W
//   zero    : result == 0
// -----------------------------------------------------------------------------
module alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALUOp,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for codes the case does not list.
    result = '0;
    case (alu_op_e'(ALUOp))
      ALU_AND:    result = A & B;
      ALU_OR:     result = A | B;
      ALU_ADD:    result = A + B;
      ALU_SUB:    result = A - B;
      ALU_PASS_B: result = B;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   EX stage of the pipeline: operand-B select, ALU, branch target and
//   branch decision, followed by the EX/MEM pipeline register.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high; clears every EX/MEM register
//   stall_EX : hold the EX/MEM register
//   flush_EX : squash the instruction in EX (control bits load 0); wins over
//              stall_EX
//   ex       : ID/EX inputs and EX/MEM outputs (execute_stage_if.slave)
// -----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall_EX,
  input  logic           flush_EX,
  execute_stage_if.slave ex
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] branch_target;
  mem_ctrl_t         ctrl_next;

  mem_ctrl_t         ctrl_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] branch_target_q;
  logic              zero_q;

  assign alu_b = ex.ALUSrc_EX ? ex.SignExtImm64_EX : ex.RegOutB_EX;

  alu #(.DATA_W(DATA_W)) u_alu (
    .A      (ex.RegOutA_EX),
    .B      (alu_b),
    .ALUOp  (ex.ALUOp_EX),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Immediate is a word offset; scale to bytes. Wraps modulo 2^DATA_W.
  assign branch_target = ex.pc_EX + (ex.SignExtImm64_EX << 2);

  // A flushed instruction still flows down as data, but with every control
  // bit cleared it becomes a bubble that cannot write or redirect the PC.
  always_comb begin
    ctrl_next           = MEM_CTRL_NOP;
    ctrl_next.reg_write = ex.RegWrite_EX;
    ctrl_next.mem_read  = ex.MemRead_EX;
    ctrl_next.mem_write = ex.MemWrite_EX;
    ctrl_next.mem2reg   = ex.Mem2Reg_EX;
    ctrl_next.pc_src    = ex.Uncondbranch_EX | (ex.Branch_EX & alu_zero);
    if (flush_EX) begin
      ctrl_next = MEM_CTRL_NOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ctrl_q          <= MEM_CTRL_NOP;
      rd_q            <= '0;
      alu_result_q    <= '0;
      write_data_q    <= '0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
    end else if (flush_EX || !stall_EX) begin
      ctrl_q          <= ctrl_next;
      rd_q            <= ex.RD_EX;
      alu_result_q    <= alu_result;
      write_data_q    <= ex.RegOutB_EX;
      branch_target_q <= branch_target;
      zero_q          <= alu_zero;
    end
  end

  assign ex.RegWrite_MEM     = ctrl_q.reg_write;
  assign ex.MemRead_MEM      = ctrl_q.mem_read;
  assign ex.MemWrite_MEM     = ctrl_q.mem_write;
  assign ex.Mem2Reg_MEM      = ctrl_q.mem2reg;
  assign ex.PCSrc_MEM        = ctrl_q.pc_src;
  assign ex.RD_MEM           = rd_q;
  assign ex.ALUResult_MEM    = alu_result_q;
  assign ex.WriteData_MEM    = write_data_q;
  assign ex.BranchTarget_MEM = branch_target_q;
  assign ex.Zero_MEM         = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed scenarios plus randomized traffic for execute_stage, compared
//   against a behavioural model of the EX/MEM register contents.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  localparam int W = 64;

  logic clk;
  logic reset;
  logic stall_EX;
  logic flush_EX;

  execute_stage_if #(.DATA_W(W)) bus ();

  execute_stage #(.DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall_EX (stall_EX),
    .flush_EX (flush_EX),
    .ex       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected EX/MEM register contents.
  logic         e_regwrite, e_memread, e_memwrite, e_mem2reg, e_pcsrc, e_zero;
  logic [4:0]   e_rd;
  logic [W-1:0] e_alu, e_wd, e_bt;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a + b;
      6:       return a - b;
      7:       return b;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    {e_regwrite, e_memread, e_memwrite, e_mem2reg, e_pcsrc, e_zero} = '0;
    e_rd = '0; e_alu = '0; e_wd = '0; e_bt = '0;
  endtask

  // What one rising edge does to the EX/MEM register, from the stage rules.
  task automatic model_edge();
    logic [W-1:0] b, res;
    if (stall_EX && !flush_EX) return;
    b   = bus.ALUSrc_EX ? bus.SignExtImm64_EX : bus.RegOutB_EX;
    res = ref_alu(int'(bus.ALUOp_EX), bus.RegOutA_EX, b);
    e_alu  = res;
    e_zero = (res == 0);
    e_rd   = bus.RD_EX;
    e_wd   = bus.RegOutB_EX;
    e_bt   = bus.pc_EX + bus.SignExtImm64_EX * 4;
    if (flush_EX) begin
      {e_regwrite, e_memread, e_memwrite, e_mem2reg, e_pcsrc} = '0;
    end else begin
      e_regwrite = bus.RegWrite_EX;
      e_memread  = bus.MemRead_EX;
      e_memwrite = bus.MemWrite_EX;
      e_mem2reg  = bus.Mem2Reg_EX;
      e_pcsrc    = bus.Uncondbranch_EX | (bus.Branch_EX & e_zero);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/RegWrite"},     W'(bus.RegWrite_MEM), W'(e_regwrite));
    check({tag, "/MemRead"},      W'(bus.MemRead_MEM),  W'(e_memread));
    check({tag, "/MemWrite"},     W'(bus.MemWrite_MEM), W'(e_memwrite));
    check({tag, "/Mem2Reg"},      W'(bus.Mem2Reg_MEM),  W'(e_mem2reg));
    check({tag, "/PCSrc"},        W'(bus.PCSrc_MEM),    W'(e_pcsrc));
    check({tag, "/RD"},           W'(bus.RD_MEM),       W'(e_rd));
    check({tag, "/ALUResult"},    bus.ALUResult_MEM,    e_alu);
    check({tag, "/WriteData"},    bus.WriteData_MEM,    e_wd);
    check({tag, "/BranchTarget"}, bus.BranchTarget_MEM, e_bt);
    check({tag, "/Zero"},         W'(bus.Zero_MEM),     W'(e_zero));
  endtask

  // Inputs are driven between edges; one rising edge, then check at negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic clear_inputs();
    bus.RegWrite_EX = 0; bus.ALUSrc_EX = 0; bus.Branch_EX = 0;
    bus.Uncondbranch_EX = 0; bus.MemRead_EX = 0; bus.MemWrite_EX = 0;
    bus.Mem2Reg_EX = 0; bus.ALUOp_EX = 4'b0000; bus.RD_EX = 5'd0;
    bus.RegOutA_EX = '0; bus.RegOutB_EX = '0; bus.SignExtImm64_EX = '0;
    bus.pc_EX = '0;
    stall_EX = 0; flush_EX = 0;
  endtask

  // Asynchronous reset pulse strictly between edges (called just after a
  // negedge); outputs must clear before the next rising edge.
  task automatic reset_pulse(input string tag);
    #1 reset = 1'b1;
    model_reset();
    #1 check_all({tag, "_async"});
    #1 reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    int sel;
    logic [W-1:0] a;
    bus.RegWrite_EX     = 1'($urandom);
    bus.ALUSrc_EX       = 1'($urandom);
    bus.Branch_EX       = 1'($urandom);
    bus.Uncondbranch_EX = ($urandom_range(0, 3) == 0);
    bus.MemRead_EX      = 1'($urandom);
    bus.MemWrite_EX     = 1'($urandom);
    bus.Mem2Reg_EX      = 1'($urandom);
    bus.RD_EX           = 5'($urandom);
    sel = $urandom_range(0, 5);
    case (sel)
      0: bus.ALUOp_EX = 4'b0000;
      1: bus.ALUOp_EX = 4'b0001;
      2: bus.ALUOp_EX = 4'b0010;
      3: bus.ALUOp_EX = 4'b0110;
      4: bus.ALUOp_EX = 4'b0111;
      default: bus.ALUOp_EX = 4'($urandom);
    endcase
    a = {$urandom, $urandom};
    bus.RegOutA_EX      = a;
    bus.RegOutB_EX      = {$urandom, $urandom};
    bus.SignExtImm64_EX = {$urandom, $urandom};
    bus.pc_EX           = {$urandom, $urandom};
    // Bias toward results of zero so the Zero flag and CBZ paths get hit.
    sel = $urandom_range(0, 7);
    if (sel == 0) bus.RegOutB_EX = a;
    if (sel == 1) bus.SignExtImm64_EX = a;
    if (sel == 2) begin bus.RegOutB_EX = '0; bus.SignExtImm64_EX = '0; end
    stall_EX = ($urandom_range(0, 3) == 0);
    flush_EX = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // ADD with immediate operand
    bus.RegOutA_EX = 64'd5; bus.ALUSrc_EX = 1; bus.SignExtImm64_EX = 64'd3;
    bus.RegOutB_EX = 64'd100; bus.ALUOp_EX = 4'b0010; bus.RD_EX = 5'd7;
    bus.RegWrite_EX = 1;
    step("add");
    check("add_result", bus.ALUResult_MEM, 64'd8);
    check("add_rd", W'(bus.RD_MEM), 64'd7);
    check("add_regwrite", W'(bus.RegWrite_MEM), 64'd1);
    check("add_zero", W'(bus.Zero_MEM), 64'd0);
    check("add_wdata_unmuxed", bus.WriteData_MEM, 64'd100);

    // CBZ taken / not taken
    clear_inputs();
    bus.Branch_EX = 1; bus.ALUOp_EX = 4'b0111; bus.RegOutB_EX = '0;
    bus.pc_EX = 64'h100; bus.SignExtImm64_EX = 64'd4;
    step("cbz_taken");
    check("cbz_pcsrc", W'(bus.PCSrc_MEM), 64'd1);
    check("cbz_target", bus.BranchTarget_MEM, 64'h110);
    check("cbz_zero", W'(bus.Zero_MEM), 64'd1);
    bus.RegOutB_EX = 64'd1;
    step("cbz_not_taken");
    check("cbz_nt_pcsrc", W'(bus.PCSrc_MEM), 64'd0);

    // SUB wrap and negative branch offset
    clear_inputs();
    bus.RegOutA_EX = '0; bus.RegOutB_EX = 64'd1; bus.ALUOp_EX = 4'b0110;
    bus.SignExtImm64_EX = -64'sd2; bus.pc_EX = 64'h10;
    step("sub_wrap");
    check("sub_result", bus.ALUResult_MEM, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sub_zero", W'(bus.Zero_MEM), 64'd0);
    check("neg_target", bus.BranchTarget_MEM, 64'h08);

    // Stall holds, then stall+flush squashes control but loads data
    clear_inputs();
    bus.MemWrite_EX = 1; bus.RegOutB_EX = 64'hAB; bus.ALUOp_EX = 4'b0010;
    bus.RegOutA_EX = 64'h40; bus.SignExtImm64_EX = 64'h8; bus.ALUSrc_EX = 1;
    step("stur");
    for (int i = 0; i < 3; i++) begin
      stall_EX = 1; bus.MemWrite_EX = 0; bus.RegWrite_EX = 1;
      bus.RegOutB_EX = 64'h1000 + 64'(i); bus.RD_EX = 5'(i + 1);
      step("stall");
      check("stall_wdata", bus.WriteData_MEM, 64'hAB);
      check("stall_memwrite", W'(bus.MemWrite_MEM), 64'd1);
    end
    stall_EX = 1; flush_EX = 1; bus.MemWrite_EX = 1; bus.RegOutB_EX = 64'hCD;
    step("stall_flush");
    check("flush_memwrite", W'(bus.MemWrite_MEM), 64'd0);
    check("flush_wdata", bus.WriteData_MEM, 64'hCD);

    // Asynchronous reset while stalled and flushed, then release under stall
    reset_pulse("rst_mid_stall_flush");
    check("rst_wdata", bus.WriteData_MEM, 64'd0);
    flush_EX = 0;
    step("post_rst_stall");

    // Reset release: first edge captures current inputs
    clear_inputs();
    bus.RegOutA_EX = 64'h11; bus.RegOutB_EX = 64'h22; bus.ALUOp_EX = 4'b0001;
    bus.RegWrite_EX = 1; bus.RD_EX = 5'd31;
    step("nonzero");
    reset_pulse("rst_release");
    check("rst_result", bus.ALUResult_MEM, 64'd0);
    step("first_capture");
    check("first_capture_result", bus.ALUResult_MEM, 64'h33);
    check("rd31_passthrough", W'(bus.RD_MEM), 64'd31);

    // Undefined ALUOp
    clear_inputs();
    bus.RegOutA_EX = 64'h55; bus.RegOutB_EX = 64'h55; bus.ALUOp_EX = 4'b1111;
    step("undef_op");
    check("undef_result", bus.ALUResult_MEM, 64'd0);
    check("undef_zero", W'(bus.Zero_MEM), 64'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if (i % 61 == 30) reset_pulse("rand_rst");
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
